// File: rtl/assoc_cache_ctrl_if.sv
// CPU-side request/response and memory-side word handshake of the 2-way cache.
// The cache takes the slave view; the pipeline/SRAM environment takes the master view.
interface assoc_cache_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              inv;
  logic              inv_busy;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, inv, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, inv_busy, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, inv, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, inv_busy, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, read-allocate, write-through cache with burst refill,
// invalidate-all sequencer and saturating read hit/miss counters.
module assoc_cache_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WORDS  = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  assoc_cache_ctrl_if.slave bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int BW    = $clog2(WORDS);
  localparam int OFF   = BW + 2;
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF - IDX;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(WORDS - 1);
  localparam logic [IDX-1:0] LAST_SET  = IDX'(SETS - 1);

  typedef enum logic [2:0] {IDLE, FILL, RESP, WRITE, INV} state_t;

  state_t            state;
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS][WORDS];
  logic [SETS-1:0]   valid    [2];
  logic [SETS-1:0]   lru;

  logic [ADDR_W-1:2] base_q;
  logic              victim_q;
  logic [BW-1:0]     beat_q;
  logic [IDX-1:0]    inv_q;
  logic [DATA_W-1:0] rdata_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [BW-1:0]    wsel, b_wsel;
  logic [IDX-1:0]   idx, b_idx;
  logic [TAG_W-1:0] tag, b_tag;
  logic             hit0, hit1, hit, hit_way, victim;
  logic             idle_wr, idle_rd, rd_hit;

  assign wsel   = bus.cpu_addr[OFF-1:2];
  assign idx    = bus.cpu_addr[OFF+IDX-1:OFF];
  assign tag    = bus.cpu_addr[ADDR_W-1:OFF+IDX];
  assign b_wsel = base_q[OFF-1:2];
  assign b_idx  = base_q[OFF+IDX-1:OFF];
  assign b_tag  = base_q[ADDR_W-1:OFF+IDX];

  assign hit0    = valid[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1    = valid[1][idx] && (tag_mem[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;
  // Fill an empty way before evicting anything; way0 wins when both are empty.
  assign victim  = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);

  assign idle_wr = (state == IDLE) && !bus.inv && bus.cpu_wr;
  assign idle_rd = (state == IDLE) && !bus.inv && !bus.cpu_wr && bus.cpu_rd;
  assign rd_hit  = idle_rd && hit;

  assign bus.cpu_ready = rd_hit || (state == RESP) || ((state == WRITE) && bus.mem_ack);
  assign bus.cpu_rdata = rd_hit ? data_mem[hit_way][idx][wsel] : rdata_q;
  assign bus.inv_busy  = (state == INV);
  assign bus.mem_rd    = (state == FILL);
  assign bus.mem_wr    = (state == WRITE);
  assign bus.mem_addr  = (state == FILL) ? {base_q[ADDR_W-1:OFF], beat_q, 2'b00} : bus.cpu_addr;
  assign bus.mem_wdata = bus.cpu_wdata;

  // Tag/data storage: no reset, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (idle_wr && hit)
      data_mem[hit_way][idx][wsel] <= bus.cpu_wdata;
    if ((state == FILL) && bus.mem_ack) begin
      data_mem[victim_q][b_idx][beat_q] <= bus.mem_rdata;
      if (beat_q == LAST_BEAT)
        tag_mem[victim_q][b_idx] <= b_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      base_q   <= '0;
      victim_q <= 1'b0;
      beat_q   <= '0;
      inv_q    <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.inv) begin
            inv_q <= '0;
            state <= INV;
          end else if (bus.cpu_wr) begin
            if (hit)
              lru[idx] <= ~hit_way;
            state <= WRITE;
          end else if (bus.cpu_rd) begin
            if (hit) begin
              hit_cnt  <= sat_inc(hit_cnt);
              lru[idx] <= ~hit_way;
            end else begin
              // The victim is invalid until its last beat lands, so an abort leaves no stale line.
              miss_cnt              <= sat_inc(miss_cnt);
              base_q                <= bus.cpu_addr[ADDR_W-1:2];
              victim_q              <= victim;
              valid[victim][idx]    <= 1'b0;
              beat_q                <= '0;
              state                 <= FILL;
            end
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            if (beat_q == b_wsel)
              rdata_q <= bus.mem_rdata;
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              valid[victim_q][b_idx] <= 1'b1;
              lru[b_idx]             <= ~victim_q;
              state                  <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        WRITE: begin
          if (bus.mem_ack)
            state <= IDLE;
        end
        INV: begin
          valid[0][inv_q] <= 1'b0;
          valid[1][inv_q] <= 1'b0;
          lru[inv_q]      <= 1'b0;
          inv_q           <= inv_q + 1'b1;
          if (inv_q == LAST_SET)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
